pixel_array_ctrl: RTL and testbench



---
 rtl/pixel_array_ctrl.sv | 134 +++++++++++++
 tb/tb_pixel_array_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the 2x2 pixel array: ERASE -> EXPOSE -> CONVERT -> READ x4 -> DONE.
// Optional CONTINUOUS_MODE_EN adds a 'continuous' input that chains frames back to back.
module pixel_array_ctrl #(
    parameter int ERASE_CYCLES   = 5,
    parameter int EXPOSE_CYCLES  = 255,
    parameter int CONVERT_CYCLES = 255,
    parameter int READ_CYCLES    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef CONTINUOUS_MODE_EN
    input  logic       continuous,
`endif
    output logic       erase,
    output logic       expose,
    output logic       ramp_en,
    output logic [7:0] counter,
    output logic       data_oe,
    output logic [3:0] read,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ,
        S_DONE
    } state_t;

    // Terminal phase-counter values; CONVERT_CYCLES=256 ends at 255 so cnt never wraps.
    localparam logic [7:0] ERASE_LAST   = 8'(ERASE_CYCLES - 1);
    localparam logic [7:0] EXPOSE_LAST  = 8'(EXPOSE_CYCLES - 1);
    localparam logic [7:0] CONVERT_LAST = 8'(CONVERT_CYCLES - 1);
    localparam logic [7:0] READ_LAST    = 8'(READ_CYCLES - 1);

    state_t     r_state, w_state_next;
    logic [7:0] r_cnt, w_cnt_next;
    logic [1:0] r_row, w_row_next;
    logic       w_chain;

`ifdef CONTINUOUS_MODE_EN
    assign w_chain = continuous;
`else
    assign w_chain = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_row   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_row   <= w_row_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 8'd1;
        w_row_next   = r_row;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = 8'd0;
                if (start) w_state_next = S_ERASE;
            end
            S_ERASE: begin
                if (r_cnt == ERASE_LAST) begin
                    w_state_next = S_EXPOSE;
                    w_cnt_next   = 8'd0;
                end
            end
            S_EXPOSE: begin
                if (r_cnt == EXPOSE_LAST) begin
                    w_state_next = S_CONVERT;
                    w_cnt_next   = 8'd0;
                end
            end
            S_CONVERT: begin
                if (r_cnt == CONVERT_LAST) begin
                    w_state_next = S_READ;
                    w_cnt_next   = 8'd0;
                    w_row_next   = 2'd0;
                end
            end
            S_READ: begin
                // Strobes abut: the next row starts on the cycle after the last one ends.
                if (r_cnt == READ_LAST) begin
                    w_cnt_next = 8'd0;
                    if (r_row == 2'd3) w_state_next = S_DONE;
                    else               w_row_next   = r_row + 2'd1;
                end
            end
            S_DONE: begin
                w_cnt_next   = 8'd0;
                w_state_next = w_chain ? S_ERASE : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 8'd0;
                w_row_next   = 2'd0;
            end
        endcase
    end

    always_comb begin
        erase      = 1'b0;
        expose     = 1'b0;
        ramp_en    = 1'b0;
        counter    = 8'd0;
        data_oe    = 1'b0;
        read       = 4'b0000;
        frame_done = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_ERASE:   erase = 1'b1;
            S_EXPOSE:  expose = 1'b1;
            S_CONVERT: begin
                ramp_en = 1'b1;
                data_oe = 1'b1;
                counter = r_cnt;
            end
            S_READ:    read = 4'b0001 << r_row;
            S_DONE:    frame_done = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Randomized scoreboard bench: three parameterizations share stimulus; a frame-position model predicts outputs.
module tb_pixel_array_ctrl;

    typedef struct packed {
        logic       erase;
        logic       expose;
        logic       ramp_en;
        logic [7:0] counter;
        logic       data_oe;
        logic [3:0] read;
        logic       busy;
        logic       frame_done;
    } out_t;

    localparam int ND = 3;
    localparam int PE [ND] = '{2, 5, 2};
    localparam int PX [ND] = '{3, 255, 3};
    localparam int PC [ND] = '{4, 255, 256};
    localparam int PR [ND] = '{2, 5, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
`ifdef CONTINUOUS_MODE_EN
    logic cont;
`endif

    out_t act [ND];
    int   pos [ND];
    out_t q   [ND][$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            logic       erase, expose, ramp_en, data_oe, busy, frame_done;
            logic [7:0] counter;
            logic [3:0] rd;
            pixel_array_ctrl #(
                .ERASE_CYCLES(PE[g]), .EXPOSE_CYCLES(PX[g]),
                .CONVERT_CYCLES(PC[g]), .READ_CYCLES(PR[g])
            ) u_dut (
                .clk(clk), .reset(rst), .start(start),
`ifdef CONTINUOUS_MODE_EN
                .continuous(cont),
`endif
                .erase(erase), .expose(expose), .ramp_en(ramp_en),
                .counter(counter), .data_oe(data_oe), .read(rd),
                .busy(busy), .frame_done(frame_done)
            );
            assign act[g] = {erase, expose, ramp_en, counter, data_oe, rd, busy, frame_done};
        end
    endgenerate

    function automatic int flen(int d);
        return PE[d] + PX[d] + PC[d] + 4 * PR[d] + 1;
    endfunction

    // Expected outputs from the position inside the frame (-1 = idle).
    function automatic out_t exp_out(int d, int p);
        out_t o;
        int   b;
        o = '0;
        if (p < 0) return o;
        o.busy = 1'b1;
        b = PE[d] + PX[d];
        if (p < PE[d])                         o.erase = 1'b1;
        else if (p < b)                        o.expose = 1'b1;
        else if (p < b + PC[d]) begin
            o.ramp_en = 1'b1;
            o.data_oe = 1'b1;
            o.counter = 8'(p - b);
        end else if (p < b + PC[d] + 4 * PR[d]) o.read = 4'b0001 << ((p - b - PC[d]) / PR[d]);
        else                                   o.frame_done = 1'b1;
        return o;
    endfunction

    // Reference model: advance the frame position at each edge, queue the expected outputs.
    initial begin
        logic c;
        for (int d = 0; d < ND; d++) pos[d] = -1;
        forever begin
            @(posedge clk);
            cyc++;
`ifdef CONTINUOUS_MODE_EN
            c = cont;
`else
            c = 1'b0;
`endif
            for (int d = 0; d < ND; d++) begin
                if (rst)                      pos[d] = -1;
                else if (pos[d] < 0)          pos[d] = start ? 0 : -1;
                else if (pos[d] == flen(d)-1) pos[d] = c ? 0 : -1;
                else                          pos[d] = pos[d] + 1;
                q[d].push_back(exp_out(d, pos[d]));
            end
        end
    end

    // Monitor: compare every presented output vector against the queued expectation.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (q[d].size() > 0) begin
                    e = q[d].pop_front();
                    checks++;
                    if (act[d] !== e) begin
                        errors++;
                        $display("FAIL outputs dut%0d cyc %0d got %h exp %h", d, cyc, act[d], e);
                    end
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        int k;
        rst   = 1'b1;
        start = 1'b0;
`ifdef CONTINUOUS_MODE_EN
        cont  = 1'b0;
`endif
        step(3);
        rst = 1'b0;
        step(2);

        // Single frame on every parameterization, including the 256-cycle convert.
        pulse_start();
        step(600);

        // start held high: frames run one after another with an idle cycle between.
        start = 1'b1;
        step(1200);
        start = 1'b0;
        step(600);

        // Reset during CONVERT with counter=2 on the small instance.
        pulse_start();
        k = 0;
        while (pos[0] != PE[0] + PX[0] + 2 && k < 100) begin
            step(1);
            k++;
        end
        checks++;
        if (k >= 100) begin
            errors++;
            $display("FAIL reach_convert timeout got %0d exp %0d", pos[0], PE[0] + PX[0] + 2);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);
        pulse_start();
        step(600);

`ifdef CONTINUOUS_MODE_EN
        cont = 1'b1;
        pulse_start();
        step(100);
        cont = 1'b0;
        step(600);
`endif

        // Random traffic: sparse starts, rare resets, occasional continuous toggles.
        repeat (3000) begin
            start = ($urandom_range(7) == 0);
            rst   = ($urandom_range(199) == 0);
`ifdef CONTINUOUS_MODE_EN
            if ($urandom_range(99) == 0) cont = ~cont;
`endif
            step(1);
        end
        rst   = 1'b0;
        start = 1'b0;
`ifdef CONTINUOUS_MODE_EN
        cont  = 1'b0;
`endif
        step(600);
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
